// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: operation codes, FSM states and op-class decode helpers for alu_mdu.
package alu_mdu_pkg;

    localparam logic [4:0] OP_AND    = 5'b00000;
    localparam logic [4:0] OP_OR     = 5'b00001;
    localparam logic [4:0] OP_ADD    = 5'b00010;
    localparam logic [4:0] OP_XOR    = 5'b00011;
    localparam logic [4:0] OP_SLL    = 5'b00100;
    localparam logic [4:0] OP_SRL    = 5'b00101;
    localparam logic [4:0] OP_SUB    = 5'b00110;
    localparam logic [4:0] OP_SRA    = 5'b00111;
    localparam logic [4:0] OP_SLT    = 5'b01000;
    localparam logic [4:0] OP_SLTU   = 5'b01001;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic is_mul(input logic [4:0] code);
        return code[4:2] == 3'b100;
    endfunction

    function automatic logic is_div(input logic [4:0] code);
        return code[4:2] == 3'b101;
    endfunction

endpackage

// File: rtl/alu_divider.sv
// alu_divider: iterative restoring divider on operand magnitudes with sign fix-up, one
// quotient bit per cycle; also flags the divide-by-zero / signed-overflow fast path.
module alu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            fast,
    output logic [XLEN-1:0] fast_quotient,
    output logic [XLEN-1:0] fast_remainder,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    logic            div_zero, overflow, a_neg, b_neg;
    logic            quo_neg, rem_neg, running;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] mag_a, mag_b, rem_q, quo_q, dvs_q, rem_next, quo_next;
    logic [XLEN:0]   partial, diff;

    assign div_zero       = (divisor == '0);
    assign overflow       = is_signed & (dividend == MOST_NEG) & (&divisor);
    assign fast           = div_zero | overflow;
    assign fast_quotient  = div_zero ? '1 : dividend;
    assign fast_remainder = div_zero ? dividend : '0;

    assign a_neg = is_signed & dividend[XLEN-1];
    assign b_neg = is_signed & divisor[XLEN-1];
    assign mag_a = a_neg ? -dividend : dividend;
    assign mag_b = b_neg ? -divisor : divisor;

    // One restoring step; a negative trial difference keeps the shifted partial remainder.
    assign partial  = {rem_q, quo_q[XLEN-1]};
    assign diff     = partial - {1'b0, dvs_q};
    assign rem_next = diff[XLEN] ? partial[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_next = {quo_q[XLEN-2:0], ~diff[XLEN]};

    // The results reflect the step in flight so the caller can register them on the last one.
    assign done      = running & (cnt == CNT_LAST);
    assign quotient  = quo_neg ? -quo_next : quo_next;
    assign remainder = rem_neg ? -rem_next : rem_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            rem_q   <= '0;
            quo_q   <= mag_a;
            dvs_q   <= mag_b;
            quo_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered RV32I ALU plus iterative RV32M multiply/divide behind valid/ready handshakes.
// Define ALU_MDU_DIV_EN to include the divider; without it the divide codes act as unknown ops.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    state_t            state, next_state;
    logic              accept, multi, finish, a_neg, b_neg, prod_neg;
    logic [4:0]        op_q;
    logic [SHW-1:0]    cnt, shamt;
    logic [XLEN-1:0]   alu_res, sra_res, finish_res, mcand;
    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] prod, prod_next, prod_fix;

`ifdef ALU_MDU_DIV_EN
    logic            div_fast, div_done, div_start;
    logic [XLEN-1:0] div_fast_q, div_fast_r, div_quo, div_rem;

    assign div_start = accept & is_div(op) & ~div_fast;
    assign multi     = is_mul(op) | (is_div(op) & ~div_fast);
    assign finish    = is_div(op_q) ? div_done : (cnt == CNT_LAST);

    alu_divider #(
        .XLEN(XLEN)
    ) u_divider (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (div_start),
        .is_signed     (~op[0]),
        .dividend      (a),
        .divisor       (b),
        .fast          (div_fast),
        .fast_quotient (div_fast_q),
        .fast_remainder(div_fast_r),
        .done          (div_done),
        .quotient      (div_quo),
        .remainder     (div_rem)
    );
`else
    assign multi  = is_mul(op);
    assign finish = (cnt == CNT_LAST);
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign shamt     = b[SHW-1:0];
    assign sra_res   = $signed(a) >>> shamt;

    // Signed multiplies run on magnitudes; the product sign is restored after the last step.
    assign a_neg     = ((op == OP_MULH) | (op == OP_MULHSU)) & a[XLEN-1];
    assign b_neg     = (op == OP_MULH) & b[XLEN-1];
    assign add_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? mcand : {XLEN{1'b0}})};
    assign prod_next = {add_sum, prod[XLEN-1:1]};
    assign prod_fix  = prod_neg ? -prod_next : prod_next;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = sra_res;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
            default: alu_res = '0;
        endcase
`ifdef ALU_MDU_DIV_EN
        if (is_div(op)) begin
            alu_res = op[1] ? div_fast_r : div_fast_q;
        end
`endif
    end

    always_comb begin
        finish_res = '0;
        case (op_q)
            OP_MUL:                       finish_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: finish_res = prod_fix[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
            OP_DIV, OP_DIVU:              finish_res = div_quo;
            OP_REM, OP_REMU:              finish_res = div_rem;
`endif
            default:                      finish_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = multi ? BUSY : DONE;
            BUSY:    if (finish)    next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            cnt      <= '0;
            mcand    <= '0;
            prod     <= '0;
            prod_neg <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= op;
                        cnt      <= '0;
                        mcand    <= a_neg ? -a : a;
                        prod     <= {{XLEN{1'b0}}, (b_neg ? -b : b)};
                        prod_neg <= a_neg ^ b_neg;
                        if (!multi) begin
                            result <= alu_res;
                            zero   <= (alu_res == '0);
                        end
                    end
                end
                BUSY: begin
                    if (finish) begin
                        result <= finish_res;
                        zero   <= (finish_res == '0);
                    end else begin
                        prod <= prod_next;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vector table, randomized ops against an arithmetic reference model,
// plus backpressure and mid-operation reset sequences for alu_mdu.
module tb_alu_mdu;

    localparam int XLEN      = 32;
    localparam int MULTI_LAT = XLEN + 1;

`ifdef ALU_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [4:0] C_AND = 5'b00000, C_OR = 5'b00001, C_ADD = 5'b00010, C_XOR = 5'b00011;
    localparam logic [4:0] C_SLL = 5'b00100, C_SRL = 5'b00101, C_SUB = 5'b00110, C_SRA = 5'b00111;
    localparam logic [4:0] C_SLT = 5'b01000, C_SLTU = 5'b01001;
    localparam logic [4:0] C_MUL = 5'b10000, C_MULH = 5'b10001, C_MULHSU = 5'b10010, C_MULHU = 5'b10011;
    localparam logic [4:0] C_DIV = 5'b10100, C_DIVU = 5'b10101, C_REM = 5'b10110, C_REMU = 5'b10111;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] expected;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    logic [4:0] op_pool[20] = '{C_AND, C_OR, C_ADD, C_XOR, C_SLL, C_SRL, C_SUB, C_SRA, C_SLT, C_SLTU,
                                C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU,
                                5'b01111, 5'b11010};

    always #5 clk = ~clk;

    alu_mdu #(
        .XLEN(XLEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .busy     (busy)
    );

    // Reference model: plain integer arithmetic on the RISC-V definitions.
    function automatic logic [31:0] refResult(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int          sx, sy;
        longint      sp;
        logic [63:0] up;
        logic        ovf;
        sx  = x;
        sy  = y;
        ovf = (x == 32'h80000000) && (y == 32'hFFFFFFFF);
        if (!DIV_EN && o[4:2] == 3'b101) return 32'h0;
        case (o)
            C_AND:    return x & y;
            C_OR:     return x | y;
            C_ADD:    return x + y;
            C_SUB:    return x - y;
            C_XOR:    return x ^ y;
            C_SLL:    return x << y[4:0];
            C_SRL:    return x >> y[4:0];
            C_SRA:    return 32'(sx >>> y[4:0]);
            C_SLT:    return (sx < sy) ? 32'd1 : 32'd0;
            C_SLTU:   return (x < y) ? 32'd1 : 32'd0;
            C_MUL:    begin up = {32'b0, x} * {32'b0, y}; return up[31:0]; end
            C_MULH:   begin sp = longint'(sx) * longint'(sy); return sp[63:32]; end
            C_MULHSU: begin sp = longint'(sx) * longint'({32'b0, y}); return sp[63:32]; end
            C_MULHU:  begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
            C_DIV:    begin
                if (y == 0) return 32'hFFFFFFFF;
                if (ovf) return x;
                return 32'(sx / sy);
            end
            C_DIVU:   return (y == 0) ? 32'hFFFFFFFF : x / y;
            C_REM:    begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                return 32'(sx % sy);
            end
            C_REMU:   return (y == 0) ? x : x % y;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int refLatency(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[4:2] == 3'b100) return MULTI_LAT;
        if (DIV_EN && o[4:2] == 3'b101 && y != 0 &&
            !(!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)) return MULTI_LAT;
        return 1;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expected);
        checks_total++;
        if (got === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, expected);
        end
    endtask

    // Issue one op, measure edges until out_valid (accept edge counts as 1), then consume it.
    task automatic applyStimulus(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] got, output logic got_zero,
                                 output int lat, output bit busy_ok);
        @(negedge clk);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 5'($urandom);
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 100) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        got      = result;
        got_zero = zero;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic runVector(input string name, input logic [4:0] o, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] expected, input int exp_lat);
        logic [31:0] got;
        logic        got_zero;
        int          lat;
        bit          busy_ok;
        applyStimulus(o, x, y, got, got_zero, lat, busy_ok);
        checkOutput({name, "_result"}, got, expected);
        checkOutput({name, "_zero"}, got_zero, expected == 0);
        checkOutput({name, "_latency"}, lat, exp_lat);
        if (exp_lat > 1) checkOutput({name, "_busy"}, busy_ok, 1'b1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0]  o;
        logic [31:0] x, y;
        bit          held_ok, ready_low, stray;

        vecs.push_back('{C_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, "add_wrap"});
        vecs.push_back('{C_SUB,    32'h00001234, 32'h00001234, 32'h00000000, 1, "sub_zero"});
        vecs.push_back('{C_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, "and"});
        vecs.push_back('{C_OR,     32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1, "or"});
        vecs.push_back('{C_XOR,    32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1, "xor"});
        vecs.push_back('{C_SLL,    32'h00000001, 32'h0000003F, 32'h80000000, 1, "sll_31"});
        vecs.push_back('{C_SRL,    32'h80000000, 32'h00000004, 32'h08000000, 1, "srl"});
        vecs.push_back('{C_SRA,    32'h80000000, 32'h00000021, 32'hC0000000, 1, "sra"});
        vecs.push_back('{C_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, "slt"});
        vecs.push_back('{C_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, "sltu"});
        vecs.push_back('{5'b01111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, "unknown_op"});
        vecs.push_back('{C_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MULTI_LAT, "mulh"});
        vecs.push_back('{C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MULTI_LAT, "mulhu"});
        vecs.push_back('{C_MUL,    32'h00000006, 32'h00000007, 32'h0000002A, MULTI_LAT, "mul"});
        vecs.push_back('{C_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MULTI_LAT, "mulhsu"});
        vecs.push_back('{C_DIV,    32'h80000000, 32'hFFFFFFFF, DIV_EN ? 32'h80000000 : 32'h0, 1, "div_ovf"});
        vecs.push_back('{C_DIVU,   32'h00000005, 32'h00000000, DIV_EN ? 32'hFFFFFFFF : 32'h0, 1, "divu_by0"});
        vecs.push_back('{C_REM,    32'hFFFFFFF9, 32'h00000002, DIV_EN ? 32'hFFFFFFFF : 32'h0,
                         DIV_EN ? MULTI_LAT : 1, "rem_neg"});
        vecs.push_back('{C_DIV,    32'hFFFFFF9C, 32'h00000007, DIV_EN ? 32'hFFFFFFF2 : 32'h0,
                         DIV_EN ? MULTI_LAT : 1, "div_neg"});
        vecs.push_back('{C_REMU,   32'h00000064, 32'h00000007, DIV_EN ? 32'h00000002 : 32'h0,
                         DIV_EN ? MULTI_LAT : 1, "remu"});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_result", result, 32'h0);
        checkOutput("reset_zero", zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            runVector(vecs[i].name, vecs[i].code, vecs[i].x, vecs[i].y, vecs[i].expected, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            o = op_pool[$urandom_range(0, 19)];
            x = pickOperand();
            y = pickOperand();
            runVector($sformatf("rand%0d_op%0h", i, o), o, x, y, refResult(o, x, y), refLatency(o, x, y));
        end

        // Backpressure: hold the result for 10 cycles while a competing request waits.
        @(negedge clk);
        op       = C_ADD;
        a        = 32'd10;
        b        = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_first_valid", out_valid, 1'b1);
        held_ok   = 1'b1;
        ready_low = 1'b1;
        @(negedge clk);
        op       = C_SUB;
        a        = 32'd100;
        b        = 32'd1;
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!out_valid || result !== 32'd30 || zero !== 1'b0) held_ok = 1'b0;
            if (in_ready) ready_low = 1'b0;
        end
        checkOutput("bp_result_held", held_ok, 1'b1);
        checkOutput("bp_in_ready_low", ready_low, 1'b1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp_consumed_valid", out_valid, 1'b0);
        checkOutput("bp_in_ready_back", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_next_valid", out_valid, 1'b1);
        checkOutput("bp_next_result", result, 32'd99);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset ten cycles into a multi-cycle op abandons it without output.
        @(negedge clk);
        op       = DIV_EN ? C_DIVU : C_MULHU;
        a        = 32'd1000;
        b        = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("midop_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midop_out_valid", out_valid, 1'b0);
        checkOutput("midop_busy", busy, 1'b0);
        checkOutput("midop_result", result, 32'h0);
        checkOutput("midop_in_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) stray = 1'b1;
        end
        checkOutput("midop_no_output", stray, 1'b0);
        runVector("post_reset_add", C_ADD, 32'd2, 32'd3, 32'd5, 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised successor to the single-cycle ALU: a registered XLEN-bit integer execution unit that covers the full RV32I ALU operation set plus the RV32M multiply/divide operations. Single-cycle operations complete in one clock. Multiply and divide iterate over XLEN cycles. Operands enter and results leave through valid/ready handshakes, so the unit sits between decode/issue and writeback of the upcoming multi-cycle core.

## Interface
- XLEN, 32: operand/result width; power of two, ≥ 8.
- SHW, $clog2(XLEN): shift-amount width (derived, not overridable).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  5  operation code (see package).
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2/imm).
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  registered result.
- zero  out  1  result == 0, for every op.
- busy  out  1  state ≠ IDLE.

## Operation
- Op codes: AND 00000, OR 00001, ADD 00010, SUB 00110, XOR 00011, SLL 00100, SRL 00101, SRA 00111, SLT 01000, SLTU 01001, MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111. Any other code gives result 0, zero 1, with single-cycle latency.
- FSM: IDLE → (accept, single-cycle op or divide fast path) DONE; IDLE → (accept, MUL*/DIV*/REM*) BUSY; BUSY → (iteration counter = XLEN-1) DONE; DONE → (out_ready) IDLE.
- Accept = in_valid & in_ready. a, b and op are captured on accept. The inputs are don't-care afterwards.
- Shifts use b[SHW-1:0]. SRA is arithmetic. SLT is signed and SLTU is unsigned; both produce 0 or 1 zero-extended.
- Arithmetic wraps modulo 2^XLEN. There is no carry or overflow output.
- Multiply uses shift-add over a 2·XLEN product register. MUL returns the low half; MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide uses restoring division on magnitudes, then applies the sign fix-up. The quotient takes the sign of a^b; the remainder takes the sign of a.
- Divide fast path takes one cycle and never enters BUSY:
  - b = 0: quotient is all-ones and remainder is a.
  - Signed a = most-negative with b = −1: quotient is a and remainder is 0.
- zero is registered together with result.
- Reset: state IDLE, out_valid 0, result 0, zero 0, busy 0, and internal counters and registers 0. in_ready is 1 while in reset.
- Reset asserted mid-operation abandons the operation with no output.

## Timing
- Single-cycle ops and the fast path: out_valid rises on the clock edge after accept (latency 1).
- MUL*/DIV*/REM*: out_valid rises XLEN+1 edges after accept (33 for XLEN = 32).
- out_valid, result and zero stay stable until the edge where out_valid & out_ready.
- The next accept is possible on the edge after that, giving a minimum of 2 cycles per op.
- in_ready is combinational from state only; it never depends on in_valid.
- out_ready asserted while out_valid is low has no effect.

## Configuration
- ALU_MDU_DIV_EN defined: the divider sub-module is instantiated and DIV/DIVU/REM/REMU behave as above.
- ALU_MDU_DIV_EN undefined: the divider is removed. The four divide codes behave as unknown ops (result 0, zero 1, latency 1). Multiply is unaffected.

## Structure
- Package alu_mdu_pkg holds:
  - the op code localparams (5-bit);
  - the FSM state enum (IDLE, BUSY, DONE);
  - helper functions for op-class decode (is_mul, is_div).
- Sub-module alu_divider holds the iterative restoring divider (start/done, XLEN-parametrised, fast-path detection inside). It is instantiated only under ALU_MDU_DIV_EN.
- Single-cycle logic and the shift-add multiplier live in the top module.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → result 0x80000000, zero 0, out_valid 1 cycle after accept. SUB a=b=0x1234 → result 0, zero 1.
- SRA a=0x80000000, b=0x21 (shift 1) → 0xC0000000. SLT a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF → 0. MULHU with the same operands → 0xFFFFFFFE. MUL 6×7 → 42. Check out_valid exactly 33 cycles after accept and busy high throughout.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 in 1 cycle. DIVU a=5, b=0 → 0xFFFFFFFF. REM a=−7, b=2 → 0xFFFFFFFF (−1).
- Backpressure: hold out_ready low for 10 cycles after a result. Check result stable, in_ready 0, and a new in_valid not accepted until one cycle after out_ready.
- Deassert rst_n 10 cycles into a DIVU. Check immediate out_valid 0, busy 0, result 0, in_ready 1. After reset is released, a new ADD 2+3 → 5 with latency 1.
